// File: rtl/flatten_buffer.sv
// Collects a frame of convolution samples into a registered flat array and holds it for the
// fully-connected stage. Optional `FLATTEN_BUFFER_RELU_EN stores negative samples as zero.
module flatten_buffer #(
  parameter int FLATTENED_LENGTH       = 50,
  parameter int CONVOLUTION_DATA_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  conv_valid,
  input  logic [CONVOLUTION_DATA_WIDTH-1:0]     conv_data,
  output logic                                  conv_ready,
  input  logic                                  frame_clear,
  output logic [CONVOLUTION_DATA_WIDTH-1:0]     flattened_outfmap [FLATTENED_LENGTH],
  output logic                                  fullyconnect_start,
  input  logic                                  fc_ack,
  output logic [$clog2(FLATTENED_LENGTH+1)-1:0] fill_count,
  output logic                                  fsm_state
);

  localparam int CW = $clog2(FLATTENED_LENGTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FLATTENED_LENGTH - 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                            state, state_next;
  logic [CW-1:0]                     count_next;
  logic                              wr_en;
  logic [CONVOLUTION_DATA_WIDTH-1:0] store_data;

`ifdef FLATTEN_BUFFER_RELU_EN
  assign store_data = conv_data[CONVOLUTION_DATA_WIDTH-1] ? '0 : conv_data;
`else
  assign store_data = conv_data;
`endif

  // Handshake: a sample transfers on a rising edge where conv_valid && conv_ready are both
  // high and frame_clear is low; conv_ready depends only on state, never on conv_valid.
  assign conv_ready = (state == FILL);
  assign fsm_state  = logic'(state);

  always_comb begin
    state_next = state;
    count_next = fill_count;
    wr_en      = 1'b0;
    if (frame_clear) begin
      state_next = FILL;
      count_next = '0;
    end else begin
      case (state)
        FILL: begin
          if (conv_valid) begin
            wr_en      = 1'b1;
            count_next = fill_count + 1'b1;
            if (fill_count == LAST_IDX) state_next = HOLD;
          end
        end
        HOLD: begin
          if (fc_ack) begin
            state_next = FILL;
            count_next = '0;
          end
        end
        default: begin
          state_next = FILL;
          count_next = '0;
        end
      endcase
    end
  end

  // Start is a separate flop loaded from the next state so it tracks HOLD exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= FILL;
      fill_count         <= '0;
      fullyconnect_start <= 1'b0;
      for (int i = 0; i < FLATTENED_LENGTH; i++) flattened_outfmap[i] <= '0;
    end else begin
      state              <= state_next;
      fill_count         <= count_next;
      fullyconnect_start <= (state_next == HOLD);
      if (wr_en) flattened_outfmap[fill_count] <= store_data;
    end
  end

endmodule

// File: tb/tb_flatten_buffer.sv
// Directed bench for flatten_buffer: fill/hold, clear priority, async reset, ReLU option,
// and two frames with gapped valid tracked through an expected queue.
module tb_flatten_buffer;

  localparam int L  = 50;
  localparam int W  = 8;
  localparam int CW = $clog2(L + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          conv_valid;
  logic [W-1:0]  conv_data;
  logic          conv_ready;
  logic          frame_clear;
  logic [W-1:0]  flattened_outfmap [L];
  logic          fullyconnect_start;
  logic          fc_ack;
  logic [CW-1:0] fill_count;
  logic          fsm_state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [$];

  flatten_buffer #(.FLATTENED_LENGTH(L), .CONVOLUTION_DATA_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .conv_valid(conv_valid), .conv_data(conv_data),
    .conv_ready(conv_ready), .frame_clear(frame_clear), .flattened_outfmap(flattened_outfmap),
    .fullyconnect_start(fullyconnect_start), .fc_ack(fc_ack), .fill_count(fill_count),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      conv_valid = 1'b1;
      conv_data  = W'(base + i);
      tick();
    end
    conv_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; conv_valid = 1'b0; conv_data = '0; frame_clear = 1'b0; fc_ack = 1'b0;
    #2;
    checks++; if (fill_count !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fill_count); end
    checks++; if (fullyconnect_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", fullyconnect_start); end
    checks++; if (flattened_outfmap[0] !== 8'h00) begin errors++; $display("FAIL reset_entry0 got=%h exp=00", flattened_outfmap[0]); end
    tick(); tick();
    reset_n = 1'b1;
    #1;
    checks++; if (conv_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", conv_ready); end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= L; i++) begin
      conv_valid = 1'b1;
      conv_data  = W'(i);
      checks++; if (conv_ready !== 1'b1) begin errors++; $display("FAIL fill_ready i=%0d got=%b exp=1", i, conv_ready); end
      checks++; if (fullyconnect_start !== 1'b0) begin errors++; $display("FAIL fill_start_early i=%0d got=%b exp=0", i, fullyconnect_start); end
      tick();
      if (i == 25) begin
        checks++; if (fill_count !== 25) begin errors++; $display("FAIL fill_mid_count got=%0d exp=25", fill_count); end
      end
    end
    conv_valid = 1'b0;
    checks++; if (fullyconnect_start !== 1'b1) begin errors++; $display("FAIL fill_start got=%b exp=1", fullyconnect_start); end
    checks++; if (fill_count !== CW'(L)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", fill_count, L); end
    checks++; if (conv_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got=%b exp=0", conv_ready); end
    for (int i = 0; i < L; i++) begin
      checks++; if (flattened_outfmap[i] !== W'(i + 1)) begin errors++; $display("FAIL fill_entry[%0d] got=%h exp=%h", i, flattened_outfmap[i], W'(i + 1)); end
    end
  endtask

  task automatic test_hold_ignore();
    for (int c = 0; c < 10; c++) begin
      conv_valid = 1'b1; conv_data = 8'hFF;
      tick();
      checks++; if (fullyconnect_start !== 1'b1) begin errors++; $display("FAIL hold_start c=%0d got=%b exp=1", c, fullyconnect_start); end
    end
    conv_valid = 1'b0; fc_ack = 1'b1;
    tick();
    fc_ack = 1'b0;
    checks++; if (fullyconnect_start !== 1'b0) begin errors++; $display("FAIL ack_start got=%b exp=0", fullyconnect_start); end
    checks++; if (fill_count !== 0) begin errors++; $display("FAIL ack_count got=%0d exp=0", fill_count); end
    checks++; if (conv_ready !== 1'b1) begin errors++; $display("FAIL ack_ready got=%b exp=1", conv_ready); end
    for (int i = 0; i < L; i++) begin
      checks++; if (flattened_outfmap[i] !== W'(i + 1)) begin errors++; $display("FAIL hold_entry[%0d] got=%h exp=%h", i, flattened_outfmap[i], W'(i + 1)); end
    end
    feed_n(1, 8'h07);
    checks++; if (flattened_outfmap[0] !== 8'h07) begin errors++; $display("FAIL b2b_entry0 got=%h exp=07", flattened_outfmap[0]); end
    checks++; if (flattened_outfmap[1] !== 8'h02) begin errors++; $display("FAIL b2b_entry1 got=%h exp=02", flattened_outfmap[1]); end
    checks++; if (fill_count !== 1) begin errors++; $display("FAIL b2b_count got=%0d exp=1", fill_count); end
  endtask

  task automatic test_frame_clear();
    feed_n(19, 8'h30);
    checks++; if (fill_count !== 20) begin errors++; $display("FAIL clr_pre_count got=%0d exp=20", fill_count); end
    conv_valid = 1'b1; conv_data = 8'hAA; frame_clear = 1'b1;
    tick();
    conv_valid = 1'b0; frame_clear = 1'b0;
    checks++; if (fill_count !== 0) begin errors++; $display("FAIL clr_count got=%0d exp=0", fill_count); end
    checks++; if (flattened_outfmap[20] !== 8'd21) begin errors++; $display("FAIL clr_entry20 got=%h exp=15", flattened_outfmap[20]); end
    checks++; if (flattened_outfmap[19] !== 8'h42) begin errors++; $display("FAIL clr_entry19 got=%h exp=42", flattened_outfmap[19]); end
    feed_n(L - 1, 8'h60);
    conv_valid = 1'b1; conv_data = 8'h5A; frame_clear = 1'b1;
    tick();
    conv_valid = 1'b0; frame_clear = 1'b0;
    checks++; if (fullyconnect_start !== 1'b0) begin errors++; $display("FAIL clr_last_start got=%b exp=0", fullyconnect_start); end
    checks++; if (fill_count !== 0) begin errors++; $display("FAIL clr_last_count got=%0d exp=0", fill_count); end
    checks++; if (flattened_outfmap[L-1] !== 8'd50) begin errors++; $display("FAIL clr_last_entry got=%h exp=32", flattened_outfmap[L-1]); end
  endtask

  task automatic test_async_reset();
    feed_n(L, 100);
    checks++; if (fullyconnect_start !== 1'b1) begin errors++; $display("FAIL ares_pre_start got=%b exp=1", fullyconnect_start); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (fullyconnect_start !== 1'b0) begin errors++; $display("FAIL ares_start got=%b exp=0", fullyconnect_start); end
    checks++; if (conv_ready !== 1'b1) begin errors++; $display("FAIL ares_ready got=%b exp=1", conv_ready); end
    checks++; if (fill_count !== 0) begin errors++; $display("FAIL ares_count got=%0d exp=0", fill_count); end
    for (int i = 0; i < L; i++) begin
      checks++; if (flattened_outfmap[i] !== 8'h00) begin errors++; $display("FAIL ares_entry[%0d] got=%h exp=00", i, flattened_outfmap[i]); end
    end
    #2 reset_n = 1'b1;
    #1;
    checks++; if (conv_ready !== 1'b1) begin errors++; $display("FAIL ares_release_ready got=%b exp=1", conv_ready); end
    tick();
  endtask

  task automatic test_ack_clear();
    logic [W-1:0] exp80;
`ifdef FLATTEN_BUFFER_RELU_EN
    exp80 = 8'h00;
`else
    exp80 = 8'h80;
`endif
    feed_n(L, 1);
    fc_ack = 1'b1; frame_clear = 1'b1;
    tick();
    fc_ack = 1'b0; frame_clear = 1'b0;
    checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL ackclr_state got=%b exp=0", fsm_state); end
    checks++; if (fill_count !== 0) begin errors++; $display("FAIL ackclr_count got=%0d exp=0", fill_count); end
    feed_n(1, 8'h80);
    checks++; if (flattened_outfmap[0] !== exp80) begin errors++; $display("FAIL relu_entry0 got=%h exp=%h", flattened_outfmap[0], exp80); end
    conv_valid = 1'b1; conv_data = 8'h11; fc_ack = 1'b1;
    tick();
    conv_valid = 1'b0; fc_ack = 1'b0;
    checks++; if (fill_count !== 2) begin errors++; $display("FAIL fill_ack_count got=%0d exp=2", fill_count); end
    checks++; if (flattened_outfmap[1] !== 8'h11) begin errors++; $display("FAIL fill_ack_entry1 got=%h exp=11", flattened_outfmap[1]); end
    frame_clear = 1'b1;
    tick();
    frame_clear = 1'b0;
  endtask

  task automatic test_gaps();
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic         v;
    int           cycles;
    for (int f = 0; f < 2; f++) begin
      cycles = 0;
      while (!fullyconnect_start && cycles < 2000) begin
        v = (cycles == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        d = W'($urandom_range(0, 127));
        conv_valid = v; conv_data = d;
        if (v && conv_ready) exp_q.push_back(d);
        tick();
        if (cycles == 0) begin
          checks++; if (fill_count !== 1) begin errors++; $display("FAIL gap_first_count f=%0d got=%0d exp=1", f, fill_count); end
        end
        cycles++;
      end
      conv_valid = 1'b0;
      checks++; if (fullyconnect_start !== 1'b1) begin errors++; $display("FAIL gap_timeout f=%0d got=%b exp=1", f, fullyconnect_start); end
      checks++; if (exp_q.size() != L) begin errors++; $display("FAIL gap_writes f=%0d got=%0d exp=%0d", f, exp_q.size(), L); end
      for (int i = 0; i < L; i++) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (flattened_outfmap[i] !== e) begin errors++; $display("FAIL gap_entry f=%0d [%0d] got=%h exp=%h", f, i, flattened_outfmap[i], e); end
      end
      exp_q.delete();
      fc_ack = 1'b1;
      tick();
      fc_ack = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hold_ignore();
    test_frame_clear();
    test_async_reset();
    test_ack_clear();
    test_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
